// File: rtl/mpu9250_pkg.sv
// Shared MPU9250 definitions: register addresses, init-table entry layout and sequencer states.
package mpu9250_pkg;

    localparam int REG_W  = 8;
    localparam int DATA_W = 8;
    localparam int DLY_W  = 8;
    localparam int STEP_W = 4;

    localparam logic [REG_W-1:0] PWR_MGMT_1   = 8'h6B;
    localparam logic [REG_W-1:0] PWR_MGMT_2   = 8'h6C;
    localparam logic [REG_W-1:0] CONFIG       = 8'h1A;
    localparam logic [REG_W-1:0] SMPLRT_DIV   = 8'h19;
    localparam logic [REG_W-1:0] GYRO_CONFIG  = 8'h1B;
    localparam logic [REG_W-1:0] ACCEL_CONFIG = 8'h1C;
    localparam logic [REG_W-1:0] INT_PIN_CFG  = 8'h37;

    typedef struct packed {
        logic [REG_W-1:0]  reg_addr;
        logic [DATA_W-1:0] data;
        logic [DLY_W-1:0]  dly;
    } seq_entry_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT_OK,
        ST_WAIT_IDLE,
        ST_DELAY,
        ST_NEXT,
        ST_DONE,
        ST_FAIL,
        ST_RETRY_WAIT
    } seq_state_t;

endpackage

// File: rtl/mpu9250_init_rom.sv
// Init table: step index -> {register, data, settle delay in DELAY_UNIT ticks}.
module mpu9250_init_rom
    import mpu9250_pkg::*;
(
    input  logic [STEP_W-1:0] step,
    output seq_entry_t        entry
);

    always_comb begin
        entry = '0;
        case (step)
            4'd0:    entry = '{PWR_MGMT_1,   8'h80, 8'd100};
            4'd1:    entry = '{PWR_MGMT_1,   8'h01, 8'd10};
            4'd2:    entry = '{PWR_MGMT_2,   8'h00, 8'd0};
            4'd3:    entry = '{CONFIG,       8'h03, 8'd0};
            4'd4:    entry = '{SMPLRT_DIV,   8'h04, 8'd0};
            4'd5:    entry = '{GYRO_CONFIG,  8'h18, 8'd0};
            4'd6:    entry = '{ACCEL_CONFIG, 8'h08, 8'd0};
            4'd7:    entry = '{INT_PIN_CFG,  8'h02, 8'd0};
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/mpu9250_init_seq.sv
// MPU9250 power-up sequencer driving the single-byte I2C write engine one entry at a time.
// Define MPU9250_INIT_RETRY_EN to reissue a NACKed or timed-out entry up to MAX_RETRY times.
//
// state      | meaning
// IDLE       | waiting for START with the engine idle
// LOAD/ISSUE | latch table entry, pulse I2C_GO
// WAIT_OK    | await OK (ACK or NACK) or timeout
// WAIT_IDLE  | await engine BUSY low
// DELAY/NEXT | settle wait, advance step
// DONE/FAIL  | result flagged, return to IDLE
// RETRY_WAIT | engine idle before reissuing the same entry
module mpu9250_init_seq
    import mpu9250_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h68,
    parameter int         NUM_STEPS  = 8,
    parameter int         DELAY_UNIT = 1024,
    parameter int         TIMEOUT    = 64,
    parameter int         MAX_RETRY  = 3
) (
    input  logic              SDA_CLK,
    input  logic              reset_n,
    input  logic              START,
    input  logic              I2C_BUSY,
    input  logic              I2C_OK,
    input  logic              I2C_ACK_ERR,
    output logic              I2C_GO,
    output logic [6:0]        I2C_ADDR,
    output logic [REG_W-1:0]  I2C_REG_ADDR,
    output logic [DATA_W-1:0] I2C_WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [STEP_W-1:0] ERR_STEP
);

    localparam int DLY_CNT_W = $clog2(255 * DELAY_UNIT + 1);
    localparam int TMO_W     = $clog2(TIMEOUT) + 1;
    // GO cycle plus TIMEOUT-1 WAIT_OK cycles puts the abort exactly TIMEOUT cycles after GO
    localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT - 2);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    seq_state_t             state_q, state_d;
    seq_entry_t             rom_entry;
    logic [STEP_W-1:0]      step_q;
    logic [DLY_W-1:0]       dly_q;
    logic [DLY_CNT_W-1:0]   dly_cnt_q;
    logic [TMO_W-1:0]       tmo_cnt_q;

    logic accept, load_entry, tmo_load, tmo_dec, dly_load, dly_dec;
    logic step_inc, set_done, set_fail;

`ifdef MPU9250_INIT_RETRY_EN
    localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);
    logic [3:0] retry_cnt_q;
    logic       retry_inc;
`else
    localparam int unused_max_retry = MAX_RETRY;
`endif

    assign I2C_ADDR = DEV_ADDR;

    mpu9250_init_rom u_rom (
        .step  (step_q),
        .entry (rom_entry)
    );

    always_ff @(posedge SDA_CLK or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        I2C_GO     = 1'b0;
        accept     = 1'b0;
        load_entry = 1'b0;
        tmo_load   = 1'b0;
        tmo_dec    = 1'b0;
        dly_load   = 1'b0;
        dly_dec    = 1'b0;
        step_inc   = 1'b0;
        set_done   = 1'b0;
        set_fail   = 1'b0;
`ifdef MPU9250_INIT_RETRY_EN
        retry_inc  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START && !I2C_BUSY) begin
                    accept  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_entry = 1'b1;
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                I2C_GO   = 1'b1;
                tmo_load = 1'b1;
                state_d  = ST_WAIT_OK;
            end
            ST_WAIT_OK: begin
                if (I2C_OK && !I2C_ACK_ERR) begin
                    state_d = ST_WAIT_IDLE;
                end else if (I2C_OK || tmo_cnt_q == '0) begin
`ifdef MPU9250_INIT_RETRY_EN
                    if (retry_cnt_q < MAX_RETRY_C) begin
                        retry_inc = 1'b1;
                        state_d   = ST_RETRY_WAIT;
                    end else begin
                        set_fail = 1'b1;
                        state_d  = ST_FAIL;
                    end
`else
                    set_fail = 1'b1;
                    state_d  = ST_FAIL;
`endif
                end else begin
                    tmo_dec = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (!I2C_BUSY) begin
                    if (dly_q != '0) begin
                        dly_load = 1'b1;
                        state_d  = ST_DELAY;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_DELAY: begin
                if (dly_cnt_q == '0) state_d = ST_NEXT;
                else                 dly_dec = 1'b1;
            end
            ST_NEXT: begin
                if (step_q == LAST_STEP) begin
                    set_done = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    step_inc = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_RETRY_WAIT: begin
                if (!I2C_BUSY) state_d = ST_ISSUE;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SDA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            step_q       <= '0;
            dly_q        <= '0;
            dly_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            I2C_REG_ADDR <= '0;
            I2C_WDATA    <= '0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            ERR          <= 1'b0;
            ERR_STEP     <= '0;
        end else begin
            if (accept) begin
                step_q   <= '0;
                BUSY     <= 1'b1;
                DONE     <= 1'b0;
                ERR      <= 1'b0;
                ERR_STEP <= '0;
            end
            if (load_entry) begin
                I2C_REG_ADDR <= rom_entry.reg_addr;
                I2C_WDATA    <= rom_entry.data;
                dly_q        <= rom_entry.dly;
            end
            if (tmo_load)     tmo_cnt_q <= TMO_LOAD;
            else if (tmo_dec) tmo_cnt_q <= tmo_cnt_q - 1'b1;
            if (dly_load)     dly_cnt_q <= DLY_CNT_W'(32'(dly_q) * DELAY_UNIT - 1);
            else if (dly_dec) dly_cnt_q <= dly_cnt_q - 1'b1;
            if (step_inc)     step_q <= step_q + 1'b1;
            if (set_done) begin
                DONE <= 1'b1;
                BUSY <= 1'b0;
            end
            if (set_fail) begin
                ERR      <= 1'b1;
                ERR_STEP <= step_q;
                BUSY     <= 1'b0;
            end
        end
    end

`ifdef MPU9250_INIT_RETRY_EN
    always_ff @(posedge SDA_CLK or negedge reset_n) begin
        if (!reset_n)                         retry_cnt_q <= '0;
        else if (accept || state_q == ST_NEXT) retry_cnt_q <= '0;
        else if (retry_inc)                   retry_cnt_q <= retry_cnt_q + 1'b1;
    end
`endif

endmodule

// File: tb/tb_mpu9250_init_seq.sv
// Bench for mpu9250_init_seq: behavioural write-engine model plus a transaction-list reference model.
`timescale 1ns/1ps
module tb_mpu9250_init_seq;

    localparam int DU    = 4;
    localparam int TMO   = 64;
    localparam int MAXR  = 3;
    localparam int NSTEP = 8;
`ifdef MPU9250_INIT_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       SDA_CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       START = 1'b0;
    logic       I2C_BUSY = 1'b0;
    logic       I2C_OK = 1'b0;
    logic       I2C_ACK_ERR = 1'b0;
    logic       I2C_GO;
    logic [6:0] I2C_ADDR;
    logic [7:0] I2C_REG_ADDR;
    logic [7:0] I2C_WDATA;
    logic       BUSY, DONE, ERR;
    logic [3:0] ERR_STEP;

    mpu9250_init_seq #(
        .DEV_ADDR   (7'h68),
        .NUM_STEPS  (NSTEP),
        .DELAY_UNIT (DU),
        .TIMEOUT    (TMO),
        .MAX_RETRY  (MAXR)
    ) dut (
        .SDA_CLK      (SDA_CLK),
        .reset_n      (reset_n),
        .START        (START),
        .I2C_BUSY     (I2C_BUSY),
        .I2C_OK       (I2C_OK),
        .I2C_ACK_ERR  (I2C_ACK_ERR),
        .I2C_GO       (I2C_GO),
        .I2C_ADDR     (I2C_ADDR),
        .I2C_REG_ADDR (I2C_REG_ADDR),
        .I2C_WDATA    (I2C_WDATA),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .ERR          (ERR),
        .ERR_STEP     (ERR_STEP)
    );

    always #5 SDA_CLK = ~SDA_CLK;

    int cyc = 0;
    always @(posedge SDA_CLK) cyc <= cyc + 1;

    // {reg, data, dly} straight from the init table
    logic [23:0] ref_tab [NSTEP] = '{24'h6B8064, 24'h6B010A, 24'h6C0000, 24'h1A0300,
                                     24'h190400, 24'h1B1800, 24'h1C0800, 24'h370200};

    int plan [NSTEP];
    int nack_left [NSTEP];
    int silent_step = -1;
    logic [15:0] go_log [$];
    int go_cyc [$];
    int ok_cyc [$];
    int fall_cyc [$];
    logic [15:0] exp_q [$];
    int exp_fail;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int find_step(input logic [15:0] rd);
        for (int i = 0; i < NSTEP; i++)
            if (ref_tab[i][23:8] == rd) return i;
        return -1;
    endfunction

    // Expected GO list: each entry is attempted until ACKed, within the allowed retry budget
    function automatic void build_expect();
        int allowed, n, att;
        allowed = RETRY ? MAXR : 0;
        exp_q.delete();
        exp_fail = -1;
        for (int i = 0; i < NSTEP; i++) begin
            n   = (i == silent_step) ? 1000 : plan[i];
            att = (n > allowed) ? allowed + 1 : n + 1;
            for (int a = 0; a < att; a++) exp_q.push_back(ref_tab[i][23:8]);
            if (n > allowed) begin
                exp_fail = i;
                break;
            end
        end
    endfunction

    // Write-engine model: BUSY on GO, OK after ~30 cycles, BUSY drops the cycle after OK
    int eng_cnt = 0;
    bit eng_act = 1'b0, eng_quiet = 1'b0, eng_nack = 1'b0;
    initial begin
        forever begin
            @(negedge SDA_CLK or negedge reset_n);
            if (!reset_n) begin
                I2C_BUSY = 1'b0; I2C_OK = 1'b0; I2C_ACK_ERR = 1'b0; eng_act = 1'b0;
            end else begin
                I2C_OK = 1'b0;
                I2C_ACK_ERR = 1'b0;
                if (eng_act) begin
                    eng_cnt--;
                    if (eng_cnt == 1 && !eng_quiet) begin
                        I2C_OK = 1'b1;
                        I2C_ACK_ERR = eng_nack;
                        ok_cyc.push_back(cyc);
                    end
                    if (eng_cnt == 0) begin
                        I2C_BUSY = 1'b0;
                        eng_act = 1'b0;
                        fall_cyc.push_back(cyc);
                    end
                end else if (I2C_GO) begin
                    int idx;
                    idx = find_step({I2C_REG_ADDR, I2C_WDATA});
                    go_log.push_back({I2C_REG_ADDR, I2C_WDATA});
                    go_cyc.push_back(cyc);
                    I2C_BUSY = 1'b1;
                    eng_act = 1'b1;
                    eng_quiet = (idx >= 0 && idx == silent_step);
                    eng_nack = 1'b0;
                    if (idx >= 0 && nack_left[idx] > 0) begin
                        eng_nack = 1'b1;
                        nack_left[idx]--;
                    end
                    eng_cnt = eng_quiet ? 8 : 30 + int'($urandom_range(0, 6));
                end
            end
        end
    end

    task automatic clear_plan();
        for (int i = 0; i < NSTEP; i++) plan[i] = 0;
        silent_step = -1;
    endtask

    task automatic run_seq(input string tag, input bit hold, input bit chk_timing);
        int k, seen_cyc, gap;
        build_expect();
        for (int i = 0; i < NSTEP; i++) nack_left[i] = plan[i];
        go_log.delete(); go_cyc.delete(); ok_cyc.delete(); fall_cyc.delete();
        @(negedge SDA_CLK);
        START = 1'b1;
        @(negedge SDA_CLK);
        if (!hold) START = 1'b0;
        chk({tag, "_busy_on"}, BUSY, 1);
        k = 0;
        while (!(DONE || ERR) && k < 20000) begin
            @(negedge SDA_CLK);
            k++;
        end
        seen_cyc = cyc;
        START = 1'b0;
        chk({tag, "_finished"}, k < 20000, 1);
        chk({tag, "_done"}, DONE, exp_fail < 0);
        chk({tag, "_err"}, ERR, exp_fail >= 0);
        chk({tag, "_err_step"}, ERR_STEP, (exp_fail < 0) ? 0 : exp_fail);
        chk({tag, "_busy_off"}, BUSY, 0);
        if (silent_step >= 0 && exp_fail == silent_step && go_cyc.size() > 0)
            chk({tag, "_timeout_cycles"}, seen_cyc - go_cyc[$], TMO);
        repeat (60) @(negedge SDA_CLK);
        chk({tag, "_go_count"}, go_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < go_log.size()) chk($sformatf("%s_go%0d", tag, i), go_log[i], exp_q[i]);
        if (chk_timing && go_cyc.size() >= 4 && ok_cyc.size() >= 3 && fall_cyc.size() >= 3) begin
            gap = go_cyc[1] - ok_cyc[0];
            chk({tag, "_dly100_gap_ok"}, gap >= 100 * DU && gap <= 100 * DU + 6, 1);
            gap = go_cyc[2] - ok_cyc[1];
            chk({tag, "_dly10_gap_ok"}, gap >= 10 * DU && gap <= 10 * DU + 6, 1);
            gap = go_cyc[3] - fall_cyc[2];
            chk({tag, "_nodly_gap_ok"}, gap >= 1 && gap <= 4, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        clear_plan();
        #1;
        chk("rst_addr", I2C_ADDR, 7'h68);
        chk("rst_go", I2C_GO, 0);
        chk("rst_reg", I2C_REG_ADDR, 0);
        chk("rst_wdata", I2C_WDATA, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_err_step", ERR_STEP, 0);
        repeat (3) @(negedge SDA_CLK);
        reset_n = 1'b1;
        repeat (2) @(negedge SDA_CLK);

        run_seq("clean", 1'b0, 1'b1);

        clear_plan(); plan[3] = 1;
        run_seq("nack1_s3", 1'b0, 1'b0);

        clear_plan(); plan[3] = 4;
        run_seq("nack4_s3", 1'b0, 1'b0);

        clear_plan(); silent_step = 2;
        run_seq("timeout_s2_hold", 1'b1, 1'b0);

        clear_plan();
        run_seq("clean_hold", 1'b1, 1'b0);

        // reset while step 5 is in WAIT_OK
        clear_plan();
        for (int i = 0; i < NSTEP; i++) nack_left[i] = 0;
        go_log.delete(); go_cyc.delete(); ok_cyc.delete(); fall_cyc.delete();
        @(negedge SDA_CLK); START = 1'b1;
        @(negedge SDA_CLK); START = 1'b0;
        k = 0;
        while (go_log.size() < 6 && k < 5000) begin
            @(negedge SDA_CLK);
            k++;
        end
        chk("midrst_reached_s5", go_log.size(), 6);
        repeat (5) @(negedge SDA_CLK);
        chk("midrst_pre_reg", I2C_REG_ADDR, 8'h1B);
        @(posedge SDA_CLK);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_go", I2C_GO, 0);
        chk("midrst_reg", I2C_REG_ADDR, 0);
        chk("midrst_wdata", I2C_WDATA, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_done", DONE, 0);
        chk("midrst_err", ERR, 0);
        chk("midrst_err_step", ERR_STEP, 0);
        chk("midrst_addr", I2C_ADDR, 7'h68);
        repeat (3) @(negedge SDA_CLK);
        reset_n = 1'b1;
        repeat (2) @(negedge SDA_CLK);
        run_seq("after_rst", 1'b0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            int s;
            clear_plan();
            s = int'($urandom_range(0, NSTEP - 1));
            plan[s] = RETRY ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) silent_step = int'($urandom_range(0, NSTEP - 1));
            run_seq($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
